axis_cpu_loader: RTL and testbench

Upstream feeder for the CPU programming port. Accepts a back-pressured AXI-Stream program image, then emits the flow-controlled-free command word sequence consumed by the daisy-chained register map. The sequence halts the target CPU, writes its jump-offset, immediate and instruction tables, and releases it. One loader drives the head of a cmd chain; the target is selected by the CPU ID in the image header.

---
 rtl/axis_cpu_loader.sv | 263 ++++++++++++++++++++++++++
 tb/tb_axis_cpu_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_cpu_loader.sv
// axis_cpu_loader: AXI-Stream program image to register-map cmd beats.
// Optional trailing checksum word: define LOADER_CKSUM_EN.
module axis_cpu_loader #(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int CPU_ID_WIDTH = 12,
  parameter logic [3:0] REG_PROG = 4'd0,
  parameter logic [3:0] REG_INST = 4'd1,
  parameter logic [3:0] REG_JMP_OFF = 4'd2,
  parameter logic [3:0] REG_IMM = 4'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] prog_in_TDATA,
  input  logic        prog_in_TVALID,
  output logic        prog_in_TREADY,
  input  logic        prog_in_TLAST,
  output logic [31:0] cmd_out_TDATA,
  output logic        cmd_out_TVALID,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = CODE_ADDR_WIDTH + 1;

`ifdef LOADER_CKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_ON_A, S_ON_D, S_BODY_A, S_BODY_D,
    S_OFF_A, S_OFF_D, S_DRAIN, S_CK
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_ON_A, S_ON_D, S_BODY_A, S_BODY_D,
    S_OFF_A, S_OFF_D, S_DRAIN
  } state_t;
`endif

  typedef enum logic [1:0] {
    PH_JMP, PH_IMM, PH_INST
  } phase_t;

  state_t state, state_n;
  phase_t phase, phase_hdr, phase_nxt;

  logic [CPU_ID_WIDTH-1:0] cpu_id;
  logic [4:0]    n_jmp, n_imm;
  logic [CW-1:0] n_inst, cnt, cnt_inc, cur_n;
  logic [31:0]   data_q;
  logic [4:0]    h_jmp, h_imm;
  logic [CW-1:0] h_inst;
  logic          h_bad;
  logic          ph_end, last_exp;
  logic [3:0]    reg_cur;
  logic [31:0]   hdr_beat, body_beat;
  logic          tready, tvalid;
  logic [31:0]   tdata;
  logic          hdr_acc, body_acc, err_set;
  logic          err_q, done_q;
`ifdef LOADER_CKSUM_EN
  logic [31:0]   sum;
`endif

  assign h_jmp  = prog_in_TDATA[19:15];
  assign h_imm  = prog_in_TDATA[14:10];
  assign h_inst = {1'b0, prog_in_TDATA[CODE_ADDR_WIDTH-1:0]} + CW'(1);
  assign h_bad  = (h_jmp > 5'd16) || (h_imm > 5'd16);

  assign cnt_inc   = cnt + CW'(1);
  assign ph_end    = (cnt_inc == cur_n);
  assign last_exp  = (phase == PH_INST) && ph_end;
  assign hdr_beat  = {cpu_id, REG_PROG, 16'h0};
  assign body_beat = {cpu_id, reg_cur, 16'h0};

  // First non-empty phase named by an incoming header
  always_comb begin
    phase_hdr = PH_INST;
    if (h_jmp != 5'd0)
      phase_hdr = PH_JMP;
    else if (h_imm != 5'd0)
      phase_hdr = PH_IMM;
  end

  // Word count, target register and successor of the current phase
  always_comb begin
    cur_n     = n_inst;
    reg_cur   = REG_INST;
    phase_nxt = PH_INST;
    unique case (phase)
      PH_JMP: begin
        cur_n     = CW'(n_jmp);
        reg_cur   = REG_JMP_OFF;
        phase_nxt = (n_imm != 5'd0) ? PH_IMM : PH_INST;
      end
      PH_IMM: begin
        cur_n   = CW'(n_imm);
        reg_cur = REG_IMM;
      end
      default: ;
    endcase
  end

  // Next state, handshake and cmd beat selection
  always_comb begin
    state_n  = state;
    tready   = 1'b0;
    tvalid   = 1'b0;
    tdata    = 32'h0;
    hdr_acc  = 1'b0;
    body_acc = 1'b0;
    err_set  = 1'b0;
    unique case (state)
      S_IDLE: begin
        tready = 1'b1;
        if (prog_in_TVALID) begin
          if (prog_in_TLAST || h_bad) begin
            err_set = 1'b1;
          end else begin
            hdr_acc = 1'b1;
            state_n = S_ON_A;
          end
        end
      end
      S_ON_A: begin
        tvalid  = 1'b1;
        tdata   = hdr_beat;
        state_n = S_ON_D;
      end
      S_ON_D: begin
        tvalid  = 1'b1;
        tdata   = 32'd1;
        state_n = S_BODY_A;
      end
      S_BODY_A: begin
        tready = 1'b1;
        if (prog_in_TVALID) begin
`ifdef LOADER_CKSUM_EN
          if (prog_in_TLAST) begin
            err_set = 1'b1;
            state_n = S_IDLE;
          end else begin
`else
          if (prog_in_TLAST && !last_exp) begin
            err_set = 1'b1;
            state_n = S_IDLE;
          end else if (!prog_in_TLAST && last_exp) begin
            err_set = 1'b1;
            state_n = S_DRAIN;
          end else begin
`endif
            tvalid   = 1'b1;
            tdata    = body_beat;
            body_acc = 1'b1;
            state_n  = S_BODY_D;
          end
        end
      end
      S_BODY_D: begin
        tvalid = 1'b1;
        tdata  = data_q;
        if (last_exp)
`ifdef LOADER_CKSUM_EN
          state_n = S_CK;
`else
          state_n = S_OFF_A;
`endif
        else
          state_n = S_BODY_A;
      end
      S_OFF_A: begin
        tvalid  = 1'b1;
        tdata   = hdr_beat;
        state_n = S_OFF_D;
      end
      S_OFF_D: begin
        tvalid  = 1'b1;
        tdata   = 32'd0;
        state_n = S_IDLE;
      end
      S_DRAIN: begin
        tready = 1'b1;
        if (prog_in_TVALID && prog_in_TLAST)
          state_n = S_IDLE;
      end
`ifdef LOADER_CKSUM_EN
      S_CK: begin
        tready = 1'b1;
        if (prog_in_TVALID) begin
          if (!prog_in_TLAST) begin
            err_set = 1'b1;
            state_n = S_DRAIN;
          end else if (prog_in_TDATA == sum) begin
            state_n = S_OFF_A;
          end else begin
            err_set = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Reset silences both streams at once, even mid-image
  assign prog_in_TREADY = tready && !rst;
  assign cmd_out_TVALID = tvalid && !rst;
  assign cmd_out_TDATA  = rst ? 32'h0 : tdata;
  assign busy           = !rst && (state != S_IDLE);
  assign done           = done_q;
  assign err            = err_q;

  // State, header fields, phase counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      phase  <= PH_JMP;
      cpu_id <= '0;
      n_jmp  <= '0;
      n_imm  <= '0;
      n_inst <= '0;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef LOADER_CKSUM_EN
      sum    <= '0;
`endif
    end else begin
      state  <= state_n;
      done_q <= (state == S_OFF_D);
      if (err_set)
        err_q <= 1'b1;
      else if (hdr_acc)
        err_q <= 1'b0;
      if (hdr_acc) begin
        cpu_id <= prog_in_TDATA[31 -: CPU_ID_WIDTH];
        n_jmp  <= h_jmp;
        n_imm  <= h_imm;
        n_inst <= h_inst;
        phase  <= phase_hdr;
        cnt    <= '0;
`ifdef LOADER_CKSUM_EN
        sum    <= '0;
`endif
      end
      if (body_acc) begin
        data_q <= prog_in_TDATA;
`ifdef LOADER_CKSUM_EN
        sum    <= sum + prog_in_TDATA;
`endif
      end
      if (state == S_BODY_D) begin
        if (ph_end) begin
          cnt   <= '0;
          phase <= phase_nxt;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_cpu_loader.sv
// tb_axis_cpu_loader: randomized images against a list-level model.
// Checksum scenarios compile in when LOADER_CKSUM_EN is defined.
module tb_axis_cpu_loader;

`ifdef LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] prog_in_TDATA;
  logic        prog_in_TVALID;
  logic        prog_in_TREADY;
  logic        prog_in_TLAST;
  logic [31:0] cmd_out_TDATA;
  logic        cmd_out_TVALID;
  logic        busy;
  logic        done;
  logic        err;

  axis_cpu_loader dut (
    .clk(clk),
    .rst(rst),
    .prog_in_TDATA(prog_in_TDATA),
    .prog_in_TVALID(prog_in_TVALID),
    .prog_in_TREADY(prog_in_TREADY),
    .prog_in_TLAST(prog_in_TLAST),
    .cmd_out_TDATA(cmd_out_TDATA),
    .cmd_out_TVALID(cmd_out_TVALID),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] beats[$];
  int          bcyc[$];
  int          acc_cyc[$];
  int          done_cnt = 0;
  int          nb_busy = 0;

  always @(negedge clk) begin
    if (cmd_out_TVALID) begin
      beats.push_back(cmd_out_TDATA);
      bcyc.push_back(cyc);
      if (!busy) nb_busy++;
    end
    if (done) done_cnt++;
    if (prog_in_TVALID && prog_in_TREADY)
      acc_cyc.push_back(cyc);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] body[$];
  logic [32:0] img[$];
  logic [31:0] exp_q[$];

  // Build header + body (+ checksum) and the beat list the spec implies
  task automatic make_image(input logic [11:0] id, input int nj,
                            input int ni, input int nin,
                            input bit fresh, input int last_at,
                            input int ck_delta);
    int total;
    logic [31:0] hdr, s;
    logic [9:0] nm1;
    total = nj + ni + nin;
    if (fresh) begin
      body.delete();
      for (int i = 0; i < total; i++) body.push_back($urandom);
    end
    nm1 = 10'(nin - 1);
    hdr = {id, 5'(nj), 5'(ni), nm1};
    img.delete();
    img.push_back({1'b0, hdr});
    s = 0;
    for (int i = 0; i < total; i++) begin
      img.push_back({(i == last_at), body[i]});
      s += body[i];
    end
    if (CK) img.push_back({1'b1, s + 32'(ck_delta)});
    exp_q.delete();
    exp_q.push_back({id, 4'd0, 16'h0});
    exp_q.push_back(32'd1);
    for (int i = 0; i < total; i++) begin
      if (i < nj) exp_q.push_back({id, 4'd2, 16'h0});
      else if (i < nj + ni) exp_q.push_back({id, 4'd3, 16'h0});
      else exp_q.push_back({id, 4'd1, 16'h0});
      exp_q.push_back(body[i]);
    end
    exp_q.push_back({id, 4'd0, 16'h0});
    exp_q.push_back(32'd0);
  endtask

  function automatic int normal_last(input int total);
    return CK ? -1 : total - 1;
  endfunction

  task automatic clear_mon();
    beats.delete();
    bcyc.delete();
    acc_cyc.delete();
    done_cnt = 0;
    nb_busy = 0;
  endtask

  // Send the first n image words (all if n<0), stalling at random
  task automatic drive_img(input int stall_pct, input int n);
    int lim;
    bit acc;
    int budget;
    lim = (n < 0) ? img.size() : n;
    for (int k = 0; k < lim; k++) begin
      while (int'($urandom_range(99)) < stall_pct) begin
        prog_in_TVALID = 1'b0;
        @(posedge clk); #1;
      end
      prog_in_TDATA  = img[k][31:0];
      prog_in_TLAST  = img[k][32];
      prog_in_TVALID = 1'b1;
      budget = 400;
      acc = 1'b0;
      while (!acc && budget > 0) begin
        @(negedge clk);
        acc = prog_in_TREADY;
        @(posedge clk); #1;
        budget--;
      end
      chk("accept", 32'(acc), 32'd1);
      prog_in_TVALID = 1'b0;
      prog_in_TLAST  = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmp_beats(input string tag);
    int n;
    chk({tag, "_len"}, 32'(beats.size()), 32'(exp_q.size()));
    n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_beat"}, beats[i], exp_q[i]);
  endtask

  task automatic cmp_pairs(input string tag);
    int bad = 0;
    for (int i = 0; i + 1 < bcyc.size(); i += 2)
      if (bcyc[i+1] != bcyc[i] + 1) bad++;
    chk({tag, "_pairgap"}, 32'(bad), 32'd0);
  endtask

  function automatic int prog0_count(input logic [11:0] id);
    int c = 0;
    for (int i = 0; i + 1 < beats.size(); i++)
      if (beats[i] == {id, 4'd0, 16'h0} && beats[i+1] == 32'd0) c++;
    return c;
  endfunction

  task automatic good_image(input string tag, input logic [11:0] id,
                            input int nj, input int ni, input int nin,
                            input int stall, input bit fresh);
    clear_mon();
    make_image(id, nj, ni, nin, fresh, normal_last(nj + ni + nin), 0);
    drive_img(stall, -1);
    idle_cycles(8);
    cmp_beats(tag);
    cmp_pairs(tag);
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_busy"}, 32'(nb_busy), 32'd0);
  endtask

  initial begin
    int nb;
    rst = 1'b1;
    prog_in_TDATA  = 32'h0;
    prog_in_TVALID = 1'b0;
    prog_in_TLAST  = 1'b0;
    idle_cycles(3);
    @(negedge clk);
    chk("rst_tvalid", 32'(cmd_out_TVALID), 32'd0);
    chk("rst_tdata", cmd_out_TDATA, 32'd0);
    chk("rst_tready", 32'(prog_in_TREADY), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tready", 32'(prog_in_TREADY), 32'd1);
    @(posedge clk); #1;

    // Reference image, no stalls: 16 contiguous beats
    good_image("plan", 12'h005, 2, 1, 3, 0, 1'b1);
    chk("plan_contig", 32'(bcyc[bcyc.size()-1] - bcyc[0]),
        32'(beats.size() - 1));
    chk("plan_lat", 32'(bcyc[0] - acc_cyc[0]), 32'd1);
    chk("plan_first_body", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);

    // Same body with random TVALID gaps
    good_image("stall", 12'h005, 2, 1, 3, 50, 1'b0);

    // Full instruction memory, no jmp/imm
    good_image("full", 12'hABC, 0, 0, 1024, 0, 1'b1);

    // Random shapes, including 16-entry tables
    for (int t = 0; t < 6; t++)
      good_image("rand", 12'($urandom), int'($urandom_range(16)),
                 int'($urandom_range(16)), int'($urandom_range(1, 20)),
                 int'($urandom_range(60)), 1'b1);
    good_image("max_tab", 12'h7F1, 16, 16, 2, 20, 1'b1);

    // TLAST on the third of six body words
    clear_mon();
    make_image(12'h005, 2, 1, 3, 1'b1, 2, 0);
    drive_img(0, 4);
    idle_cycles(6);
    for (int i = 0; i < 6; i++) chk("early_prefix", beats[i], exp_q[i]);
    chk("early_prog0", 32'(prog0_count(12'h005)), 32'd0);
    chk("early_err", 32'(err), 32'd1);
    chk("early_idle", 32'(busy), 32'd0);
    chk("early_done", 32'(done_cnt), 32'd0);
    good_image("recover1", 12'h005, 2, 1, 3, 0, 1'b1);

    // Last expected word without TLAST, then junk up to TLAST
    clear_mon();
    make_image(12'h00A, 2, 1, 3, 1'b1, -1, 0);
    if (CK) void'(img.pop_back());
    img.push_back({1'b0, 32'h1234_5678});
    img.push_back({1'b0, 32'hFFFF_FFFF});
    img.push_back({1'b1, 32'h0000_0001});
    drive_img(30, -1);
    idle_cycles(6);
    chk("drain_nbeats_le", 32'(beats.size() <= 14), 32'd1);
    chk("drain_prog0", 32'(prog0_count(12'h00A)), 32'd0);
    chk("drain_err", 32'(err), 32'd1);
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_done", 32'(done_cnt), 32'd0);
    good_image("recover2", 12'h00A, 1, 2, 4, 0, 1'b1);

`ifdef LOADER_CKSUM_EN
    // Checksum off by one
    clear_mon();
    make_image(12'h033, 2, 1, 3, 1'b1, -1, 1);
    drive_img(0, -1);
    idle_cycles(6);
    chk("ck_bad_prog0", 32'(prog0_count(12'h033)), 32'd0);
    chk("ck_bad_err", 32'(err), 32'd1);
    chk("ck_bad_done", 32'(done_cnt), 32'd0);
    chk("ck_bad_idle", 32'(busy), 32'd0);
    good_image("ck_good", 12'h033, 2, 1, 3, 25, 1'b0);
`endif

    // Reset in the middle of the body
    clear_mon();
    make_image(12'h0F0, 3, 2, 5, 1'b1, normal_last(10), 0);
    drive_img(0, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(cmd_out_TVALID), 32'd0);
    chk("mid_rst_tready", 32'(prog_in_TREADY), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    nb = beats.size();
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(10);
    chk("mid_rst_nobeats", 32'(beats.size()), 32'(nb));
    chk("mid_rst_err", 32'(err), 32'd0);
    good_image("after_rst", 12'h0F0, 1, 1, 1, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
